// File: rtl/ffd_pkg.sv
// Shared definitions for the ffd_shift_n register family: mode encodings and
// a constant-evaluable ceiling-log2 used to size the shift counter.
package ffd_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;
    localparam logic [2:0] MODE_ROR  = 3'd5;
    localparam logic [2:0] MODE_CLR  = 3'd6;
    localparam logic [2:0] MODE_RSVD = 3'd7;

    // Smallest n with 2**n >= value; usable in parameter and port declarations.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ffd_vec.sv
// Parametrised WIDTH-bit D register with clock enable and asynchronous
// active-high reset to RESET_VAL.
module ffd_vec #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge CLK or posedge RESET) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (RESET) begin
            Q <= RESET_VAL;
        end else if (ENABLE) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/ffd_shift_n.sv
// WIDTH-bit mode-selected register: hold/load/shift/rotate/clear with a
// saturating shift counter. Define FFD_SHIFT_PAR_OUT_EN to add PAR_VALID.
module ffd_shift_n
    import ffd_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          ENABLE,
    input  logic [2:0]                    MODE,
    input  logic [WIDTH-1:0]              D,
    input  logic                          SIN,
    output logic [WIDTH-1:0]              Q,
    output logic                          SOUT,
    output logic [clog2(WIDTH+1)-1:0]     SHIFT_CNT,
    output logic                          DONE
`ifdef FFD_SHIFT_PAR_OUT_EN
    ,
    output logic                          PAR_VALID
`endif
);

    localparam int            CW      = clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] q_next;
    logic             sout_next;
    logic [CW-1:0]    cnt_next;
    logic             is_shift;

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        q_next    = Q;
        sout_next = SOUT;
        cnt_next  = SHIFT_CNT;
        is_shift  = 1'b0;
        case (MODE)
            MODE_LOAD: begin
                q_next   = D;
                cnt_next = '0;
            end
            MODE_SHL: begin
                q_next    = {Q[WIDTH-2:0], SIN};
                sout_next = Q[WIDTH-1];
                is_shift  = 1'b1;
            end
            MODE_SHR: begin
                q_next    = {SIN, Q[WIDTH-1:1]};
                sout_next = Q[0];
                is_shift  = 1'b1;
            end
            MODE_ROL: begin
                q_next    = {Q[WIDTH-2:0], Q[WIDTH-1]};
                sout_next = Q[WIDTH-1];
                is_shift  = 1'b1;
            end
            MODE_ROR: begin
                q_next    = {Q[0], Q[WIDTH-1:1]};
                sout_next = Q[0];
                is_shift  = 1'b1;
            end
            MODE_CLR: begin
                q_next    = '0;
                sout_next = 1'b0;
                cnt_next  = '0;
            end
            MODE_HOLD, MODE_RSVD: ;
            default: ;
        endcase
        // Counter saturates at WIDTH while the data path keeps shifting.
        if (is_shift && (SHIFT_CNT != CNT_MAX)) begin
            cnt_next = SHIFT_CNT + CW'(1);
        end
    end

    ffd_vec #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_q (
        .CLK    (CLK),
        .RESET  (RESET),
        .ENABLE (ENABLE),
        .D      (q_next),
        .Q      (Q)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SOUT      <= 1'b0;
            SHIFT_CNT <= '0;
        end else if (ENABLE) begin
            SOUT      <= sout_next;
            SHIFT_CNT <= cnt_next;
        end
    end

    assign DONE = (SHIFT_CNT == CNT_MAX);

`ifdef FFD_SHIFT_PAR_OUT_EN
    // Updated every edge (not gated by ENABLE) so the pulse lasts exactly one cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            PAR_VALID <= 1'b0;
        end else begin
            PAR_VALID <= ENABLE && is_shift && (SHIFT_CNT == CNT_MAX - CW'(1));
        end
    end
`endif

endmodule

// File: tb/tb_ffd_shift_n.sv
// Self-checking bench for ffd_shift_n (WIDTH=8): a RESET_VAL=0 and a
// RESET_VAL=0x3C instance share stimulus and are compared to an arithmetic model.
module tb_ffd_shift_n;
    import ffd_pkg::*;

    localparam int W    = 8;
    localparam int FULL = 1 << W;
    localparam int HALF = 1 << (W - 1);

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [2:0]   mode;
    logic [W-1:0] d;
    logic         sin;

    logic [W-1:0] q_a, q_b;
    logic         sout_a, sout_b;
    logic [3:0]   cnt_a, cnt_b;
    logic         done_a, done_b;
`ifdef FFD_SHIFT_PAR_OUT_EN
    logic         pv_a, pv_b;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Model state per instance: [0] RESET_VAL=0, [1] RESET_VAL=0x3C.
    int rv[2] = '{0, 'h3C};
    int mq[2];
    int ms[2];
    int mc[2];
    int mp[2];

    always #5 clk = ~clk;

    ffd_shift_n #(.WIDTH(W), .RESET_VAL(8'h00)) dut_a (
        .CLK       (clk),
        .RESET     (reset),
        .ENABLE    (enable),
        .MODE      (mode),
        .D         (d),
        .SIN       (sin),
        .Q         (q_a),
        .SOUT      (sout_a),
        .SHIFT_CNT (cnt_a),
        .DONE      (done_a)
`ifdef FFD_SHIFT_PAR_OUT_EN
        ,
        .PAR_VALID (pv_a)
`endif
    );

    ffd_shift_n #(.WIDTH(W), .RESET_VAL(8'h3C)) dut_b (
        .CLK       (clk),
        .RESET     (reset),
        .ENABLE    (enable),
        .MODE      (mode),
        .D         (d),
        .SIN       (sin),
        .Q         (q_b),
        .SOUT      (sout_b),
        .SHIFT_CNT (cnt_b),
        .DONE      (done_b)
`ifdef FFD_SHIFT_PAR_OUT_EN
        ,
        .PAR_VALID (pv_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i] = rv[i];
            ms[i] = 0;
            mc[i] = 0;
            mp[i] = 0;
        end
    endtask

    task automatic model_step(input int m, input int dd, input int s, input bit en);
        for (int i = 0; i < 2; i++) begin
            int old_q;
            old_q = mq[i];
            mp[i] = 0;
            if (en) begin
                if (m >= 2 && m <= 5) begin
                    mp[i] = (mc[i] == W - 1) ? 1 : 0;
                    mc[i] = (mc[i] < W) ? mc[i] + 1 : W;
                end
                case (m)
                    1: begin mq[i] = dd; mc[i] = 0; end
                    2: begin ms[i] = old_q / HALF; mq[i] = (old_q * 2 + s) % FULL; end
                    3: begin ms[i] = old_q % 2;    mq[i] = old_q / 2 + s * HALF; end
                    4: begin ms[i] = old_q / HALF; mq[i] = (old_q * 2) % FULL + old_q / HALF; end
                    5: begin ms[i] = old_q % 2;    mq[i] = old_q / 2 + (old_q % 2) * HALF; end
                    6: begin mq[i] = 0; ms[i] = 0; mc[i] = 0; end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".a.q"},    q_a,    mq[0]);
        check({tag, ".a.sout"}, sout_a, ms[0]);
        check({tag, ".a.cnt"},  cnt_a,  mc[0]);
        check({tag, ".a.done"}, done_a, (mc[0] == W) ? 1 : 0);
        check({tag, ".b.q"},    q_b,    mq[1]);
        check({tag, ".b.sout"}, sout_b, ms[1]);
        check({tag, ".b.cnt"},  cnt_b,  mc[1]);
        check({tag, ".b.done"}, done_b, (mc[1] == W) ? 1 : 0);
`ifdef FFD_SHIFT_PAR_OUT_EN
        check({tag, ".a.pv"},   pv_a,   mp[0]);
        check({tag, ".b.pv"},   pv_b,   mp[1]);
`endif
    endtask

    // Drive inputs away from the edge, clock once, then compare 1 time unit later.
    task automatic step(input string tag, input logic [2:0] m, input logic [W-1:0] dd,
                        input logic s, input logic en);
        mode   = m;
        d      = dd;
        sin    = s;
        enable = en;
        @(posedge clk);
        #1;
        model_step(int'(m), int'(dd), int'(s), en);
        check_all(tag);
    endtask

    // Assert reset between edges; outputs must change without any clock edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        reset  = 1'b0;
        enable = 1'b0;
        mode   = MODE_HOLD;
        d      = '0;
        sin    = 1'b0;

        // 1: asynchronous reset before the first edge, held across an edge.
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_held");
        #2;
        reset = 1'b0;

        // First enabled edge after release works on RESET_VAL with count 0.
        step("post_rst_shl", MODE_SHL, 8'h00, 1'b1, 1'b1);

        // 2: load then 9 logical left shifts with SIN=0.
        step("t2_load", MODE_LOAD, 8'hA5, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step($sformatf("t2_shl%0d", i), MODE_SHL, 8'h00, 1'b0, 1'b1);
        check("t2_q_explicit", q_a, 32'h00);
        check("t2_cnt_sat", cnt_a, 32'd8);

        // 3: rotates.
        step("t3_load", MODE_LOAD, 8'h81, 1'b0, 1'b1);
        step("t3_rol", MODE_ROL, 8'h00, 1'b0, 1'b1);
        check("t3_rol_q_explicit", q_a, 32'h03);
        step("t3_ror0", MODE_ROR, 8'h00, 1'b1, 1'b1);
        step("t3_ror1", MODE_ROR, 8'h00, 1'b1, 1'b1);
        check("t3_ror_q_explicit", q_a, 32'hC0);

        // 4: enable low freezes everything; reserved mode holds.
        step("t4_load", MODE_LOAD, 8'h5A, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step($sformatf("t4_dis%0d", i), MODE_SHL, 8'hFF, 1'b1, 1'b0);
        step("t4_rsvd", MODE_RSVD, 8'hFF, 1'b1, 1'b1);
        step("t4_hold", MODE_HOLD, 8'h33, 1'b1, 1'b1);

        // 5: serial deserialise through SHR.
        step("t5_clr", MODE_CLR, 8'h00, 1'b0, 1'b1);
        pat = 8'b0101_0011;
        for (int i = 0; i < 8; i++) step($sformatf("t5_shr%0d", i), MODE_SHR, 8'h00, pat[i], 1'b1);
        check("t5_q_explicit", q_a, 32'h53);
        step("t5_shr_extra", MODE_SHR, 8'h00, 1'b1, 1'b1);

        // 6: reset mid-sequence, then CLR after a few shifts.
        step("t6_load", MODE_LOAD, 8'hC3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step($sformatf("t6_shl%0d", i), MODE_SHL, 8'h00, 1'b1, 1'b1);
        async_reset("t6_rst");
        for (int i = 0; i < 3; i++) step($sformatf("t6_rol%0d", i), MODE_ROL, 8'h00, 1'b0, 1'b1);
        step("t6_clr", MODE_CLR, 8'h00, 1'b1, 1'b1);

        // Randomised traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                async_reset($sformatf("rnd_rst%0d", i));
            end else begin
                step($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), 8'($urandom),
                     1'($urandom), ($urandom_range(0, 3) != 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
